// File: rtl/frame_align_ctrl_pkg.sv
// Shared types and constants for the frame-alignment controller.
package frame_align_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_LOCK   = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    localparam int SLIP_W = 5;
    localparam int CNT_W  = 4;
    localparam logic [SLIP_W-1:0] SLIP_SAT = 5'd31;
    localparam logic [7:0] DEF_FRAME_PATTERN = 8'hF0;
endpackage

// File: rtl/frame_align_cnt.sv
// Generic counter: clear > load > step, with an equality terminal-count flag.
module frame_align_cnt #(
    parameter int W    = 4,
    parameter bit DOWN = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic         tc
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cnt <= '0;
        else if (clr)   cnt <= '0;
        else if (load)  cnt <= load_val;
        else if (en)    cnt <= DOWN ? cnt - W'(1) : cnt + W'(1);
    end

    assign tc = (cnt == tc_val);
endmodule

// File: rtl/frame_align_ctrl.sv
// Frame-alignment FSM: slips all deserializers until the frame word matches, then tracks lock.
// Optional FRAME_ALIGN_AUTO_RELOCK_EN: on loss of lock, retry alignment instead of idling.
module frame_align_ctrl
    import frame_align_ctrl_pkg::*;
#(
    parameter logic [7:0] FRAME_PATTERN = DEF_FRAME_PATTERN,
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_SLIPS     = 16,
    parameter int LOCK_COUNT    = 8,
    parameter int LOSS_COUNT    = 4
) (
    input  logic              GCLK,
    input  logic              RESETN,
    input  logic [7:0]        FCLK_DATA,
    input  logic              ALIGN_START,
    output logic              BITSLIP,
    output logic              LOCKED,
    output logic              ALIGN_FAIL,
    output logic              LOCK_LOST,
    output logic [SLIP_W-1:0] SLIP_COUNT,
    output logic [2:0]        STATE
);
    state_t state, next;
    logic   init_pend, lose, slip_clr;
    logic   settle_tc, match_tc, miss_tc;
    logic   match;

    assign match = (FCLK_DATA == FRAME_PATTERN);

    // Settle counter reloads on every entry, including repeated ALIGN_START while settling.
    frame_align_cnt #(.W(CNT_W), .DOWN(1'b1)) u_settle (
        .clk(GCLK), .rst_n(RESETN), .clr(1'b0),
        .load((next == ST_SETTLE) && ((state != ST_SETTLE) || ALIGN_START)),
        .load_val(CNT_W'(SETTLE_CYCLES)),
        .en(state == ST_SETTLE),
        .tc_val(CNT_W'(1)), .tc(settle_tc)
    );

    frame_align_cnt #(.W(CNT_W), .DOWN(1'b0)) u_match (
        .clk(GCLK), .rst_n(RESETN),
        .clr(ALIGN_START || (state != ST_CHECK) || !match),
        .load(1'b0), .load_val('0),
        .en((state == ST_CHECK) && match),
        .tc_val(CNT_W'(LOCK_COUNT - 1)), .tc(match_tc)
    );

    frame_align_cnt #(.W(CNT_W), .DOWN(1'b0)) u_miss (
        .clk(GCLK), .rst_n(RESETN),
        .clr(ALIGN_START || (state != ST_LOCK) || match),
        .load(1'b0), .load_val('0),
        .en((state == ST_LOCK) && !match),
        .tc_val(CNT_W'(LOSS_COUNT - 1)), .tc(miss_tc)
    );

    always_comb begin
        next = state;
        lose = 1'b0;
        if (ALIGN_START) begin
            next = ST_SETTLE;
        end else begin
            case (state)
                ST_IDLE:   if (init_pend) next = ST_SETTLE;
                ST_SETTLE: if (settle_tc) next = ST_CHECK;
                ST_CHECK: begin
                    if (match) begin
                        if (match_tc) next = ST_LOCK;
                    end else if (SLIP_COUNT == SLIP_W'(MAX_SLIPS)) begin
                        next = ST_FAIL;
                    end else begin
                        next = ST_SLIP;
                    end
                end
                ST_SLIP:   next = ST_SETTLE;
                ST_LOCK: begin
                    if (!match && miss_tc) begin
                        lose = 1'b1;
`ifdef FRAME_ALIGN_AUTO_RELOCK_EN
                        next = ST_SETTLE;
`else
                        next = ST_IDLE;
`endif
                    end
                end
                ST_FAIL:   next = ST_FAIL;
                default:   next = ST_IDLE;
            endcase
        end
    end

`ifdef FRAME_ALIGN_AUTO_RELOCK_EN
    assign slip_clr = ALIGN_START || lose;
`else
    assign slip_clr = ALIGN_START;
`endif

    // Outputs are decoded from next so they are flops aligned with the state register.
    always_ff @(posedge GCLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= ST_IDLE;
            init_pend  <= 1'b1;
            BITSLIP    <= 1'b0;
            LOCKED     <= 1'b0;
            ALIGN_FAIL <= 1'b0;
            LOCK_LOST  <= 1'b0;
            SLIP_COUNT <= '0;
        end else begin
            state      <= next;
            BITSLIP    <= (next == ST_SLIP);
            LOCKED     <= (next == ST_LOCK);
            ALIGN_FAIL <= (next == ST_FAIL);
            if ((state == ST_IDLE) && (next != ST_IDLE)) init_pend <= 1'b0;
            if (ALIGN_START)  LOCK_LOST <= 1'b0;
            else if (lose)    LOCK_LOST <= 1'b1;
            if (slip_clr)                                      SLIP_COUNT <= '0;
            else if ((next == ST_SLIP) && (SLIP_COUNT != SLIP_SAT)) SLIP_COUNT <= SLIP_COUNT + 5'd1;
        end
    end

    assign STATE = state;
endmodule

// File: tb/tb_frame_align_ctrl.sv
// Directed bench for frame_align_ctrl: startup lock, slip loop, fail, loss of lock, restart, async reset.
module tb_frame_align_ctrl;
    logic       GCLK = 1'b0;
    logic       RESETN = 1'b0;
    logic [7:0] FCLK_DATA = 8'hF0;
    logic       ALIGN_START = 1'b0;
    logic       BITSLIP, LOCKED, ALIGN_FAIL, LOCK_LOST;
    logic [4:0] SLIP_COUNT;
    logic [2:0] STATE;

    frame_align_ctrl dut (
        .GCLK(GCLK), .RESETN(RESETN), .FCLK_DATA(FCLK_DATA), .ALIGN_START(ALIGN_START),
        .BITSLIP(BITSLIP), .LOCKED(LOCKED), .ALIGN_FAIL(ALIGN_FAIL), .LOCK_LOST(LOCK_LOST),
        .SLIP_COUNT(SLIP_COUNT), .STATE(STATE)
    );

    always #5 GCLK = ~GCLK;

    typedef struct {
        logic [7:0] data;
        logic       locked;
        logic       lost;
        logic [2:0] st;
    } vec_t;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    bit         model_en = 1'b0;
    logic [7:0] word = 8'hF0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock; sample 1ns after the edge. The model slips the frame word on BITSLIP.
    task automatic tick();
        @(posedge GCLK);
        #1;
        cyc++;
        if (model_en && BITSLIP) begin
            word = {word[6:0], word[7]};
            FCLK_DATA = word;
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_bitslip"}, BITSLIP, 1'b0);
        check({tag, "_locked"}, LOCKED, 1'b0);
        check({tag, "_fail"}, ALIGN_FAIL, 1'b0);
        check({tag, "_lost"}, LOCK_LOST, 1'b0);
        check({tag, "_slipcnt"}, SLIP_COUNT, 5'd0);
        check({tag, "_state"}, STATE, 3'd0);
    endtask

    vec_t tbl [8];
    int   slip_at [$];
    int   nslip;
    bit   seen_bs;

    initial begin
        // 3 bad, 1 good, 4 bad while locked: only the 4th consecutive bad word drops lock.
        tbl[0] = '{8'h00, 1'b1, 1'b0, 3'd4};
        tbl[1] = '{8'h0F, 1'b1, 1'b0, 3'd4};
        tbl[2] = '{8'hE1, 1'b1, 1'b0, 3'd4};
        tbl[3] = '{8'hF0, 1'b1, 1'b0, 3'd4};
        tbl[4] = '{8'hAA, 1'b1, 1'b0, 3'd4};
        tbl[5] = '{8'h55, 1'b1, 1'b0, 3'd4};
        tbl[6] = '{8'hFF, 1'b1, 1'b0, 3'd4};
`ifdef FRAME_ALIGN_AUTO_RELOCK_EN
        tbl[7] = '{8'h78, 1'b0, 1'b1, 3'd1};
`else
        tbl[7] = '{8'h78, 1'b0, 1'b1, 3'd0};
`endif

        // ---- reset, aligned input: lock 13 cycles after release, no slips
        repeat (3) tick();
        check_reset_outs("rst");
        RESETN = 1'b1;
        cyc = 0;
        seen_bs = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (BITSLIP) seen_bs = 1'b1;
            if (k == 1)  check("start_settle", STATE, 3'd1);
            if (k == 5)  check("start_check", STATE, 3'd2);
            if (k == 12) check("lock_not_yet", LOCKED, 1'b0);
        end
        check("lock_at_13", LOCKED, 1'b1);
        check("lock_state", STATE, 3'd4);
        check("lock_slipcnt", SLIP_COUNT, 5'd0);
        check("aligned_no_bitslip", seen_bs, 1'b0);

        // ---- loss-of-lock table
        foreach (tbl[i]) begin
            FCLK_DATA = tbl[i].data;
            tick();
            check($sformatf("loss%0d_locked", i), LOCKED, tbl[i].locked);
            check($sformatf("loss%0d_lost", i), LOCK_LOST, tbl[i].lost);
            check($sformatf("loss%0d_state", i), STATE, tbl[i].st);
        end
        FCLK_DATA = 8'hF0;
`ifdef FRAME_ALIGN_AUTO_RELOCK_EN
        for (int k = 0; k < 40 && !LOCKED; k++) tick();
        check("relock", LOCKED, 1'b1);
        check("relock_lost_sticky", LOCK_LOST, 1'b1);
`else
        repeat (5) tick();
        check("idle_waits", STATE, 3'd0);
`endif

        // ---- rotating model, 3 slips from the pattern
        RESETN = 1'b0;
        #2;
        word = 8'h1E;
        FCLK_DATA = word;
        model_en = 1'b1;
        tick();
        RESETN = 1'b1;
        cyc = 0;
        slip_at.delete();
        for (int k = 0; k < 200 && !LOCKED; k++) begin
            tick();
            if (BITSLIP) slip_at.push_back(cyc);
        end
        check("rot_locked", LOCKED, 1'b1);
        check("rot_nslip", slip_at.size(), 3);
        check("rot_slipcnt", SLIP_COUNT, 5'd3);
        if (slip_at.size() == 3) begin
            check("rot_first_slip", slip_at[0], 6);
            check("rot_gap1", slip_at[1] - slip_at[0], 6);
            check("rot_gap2", slip_at[2] - slip_at[1], 6);
        end
        model_en = 1'b0;

        // ---- never-matching input: 16 slips then FAIL
        FCLK_DATA = 8'hAA;
        ALIGN_START = 1'b1;
        tick();
        ALIGN_START = 1'b0;
        check("restart_unlock", LOCKED, 1'b0);
        nslip = 0;
        for (int k = 0; k < 400 && STATE != 3'd5; k++) begin
            tick();
            if (BITSLIP) nslip++;
        end
        check("fail_nslip", nslip, 16);
        check("fail_flag", ALIGN_FAIL, 1'b1);
        check("fail_state", STATE, 3'd5);
        check("fail_locked", LOCKED, 1'b0);
        check("fail_slipcnt", SLIP_COUNT, 5'd16);
        repeat (10) tick();
        check("fail_stays", STATE, 3'd5);

        // ---- ALIGN_START during the settle after slip #2
        ALIGN_START = 1'b1;
        tick();
        ALIGN_START = 1'b0;
        check("fail_cleared", ALIGN_FAIL, 1'b0);
        check("restart_slipcnt", SLIP_COUNT, 5'd0);
        nslip = 0;
        for (int k = 0; k < 100 && nslip < 2; k++) begin
            tick();
            if (BITSLIP) nslip++;
        end
        check("two_slips", nslip, 2);
        tick();
        tick();
        check("mid_settle", STATE, 3'd1);
        check("mid_settle_slipcnt", SLIP_COUNT, 5'd2);
        ALIGN_START = 1'b1;
        tick();
        ALIGN_START = 1'b0;
        check("restart_clr_slipcnt", SLIP_COUNT, 5'd0);
        check("restart_settle", STATE, 3'd1);
        repeat (3) tick();
        check("full_settle", STATE, 3'd1);
        tick();
        check("settle_done", STATE, 3'd2);

        // ---- reset during SLIP truncates the pulse
        seen_bs = 1'b0;
        for (int k = 0; k < 100 && !seen_bs; k++) begin
            tick();
            if (BITSLIP) seen_bs = 1'b1;
        end
        check("slip_seen", seen_bs, 1'b1);
        #2;
        RESETN = 1'b0;
        #1;
        check_reset_outs("async");
        FCLK_DATA = 8'hF0;
        #2;
        RESETN = 1'b1;
        for (int k = 0; k < 13; k++) tick();
        check("relock_after_reset", LOCKED, 1'b1);
        check("relock_after_reset_slips", SLIP_COUNT, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/frame_align_ctrl.md
# frame_align_ctrl

Frame-alignment controller for the 4-channel DDR ADC deserializer. It watches the 8-bit parallel frame-clock word from the frame deserializer and issues single-cycle bitslip pulses until the word matches the expected frame pattern. It then declares lock and monitors for loss of lock. Its BITSLIP output drives the bitslip/sync input of the frame deserializer and all four data-channel deserializers, so every lane slips together.

## Interface
- FRAME_PATTERN, 8'hF0, expected aligned frame word
- SETTLE_CYCLES, 4, GCLK cycles ignored after any slip or restart (deserializer pipeline flush), range 1..15
- MAX_SLIPS, 16, slips attempted before declaring failure, range 1..31
- LOCK_COUNT, 8, consecutive matching words required to lock, range 1..15
- LOSS_COUNT, 4, consecutive mismatching words in LOCKED that drop lock, range 1..15
- GCLK  in  1  parallel-domain clock; all logic is on the rising edge
- RESETN  in  1  asynchronous, active-low reset
- FCLK_DATA  in  8  parallel frame word, one valid word per GCLK cycle
- ALIGN_START  in  1  level-sampled restart request, acted on in any state
- BITSLIP  out  1  one-cycle slip pulse to all deserializers
- LOCKED  out  1  frame aligned and stable
- ALIGN_FAIL  out  1  MAX_SLIPS exhausted without lock
- LOCK_LOST  out  1  sticky flag; lock dropped since the last ALIGN_START
- SLIP_COUNT  out  5  slips issued in the current attempt, saturating at 31
- STATE  out  3  FSM state encoding for debug

## Operation
- States and encodings: IDLE=0, SETTLE=1, CHECK=2, SLIP=3, LOCK=4, FAIL=5.
- Internal flag init_pend is set to 1 by reset and cleared on leaving IDLE. It gives an automatic first alignment after reset.
- IDLE -> SETTLE when init_pend=1 or ALIGN_START=1.
- SETTLE:
  - A down-counter loads SETTLE_CYCLES on entry.
  - FCLK_DATA is ignored.
  - -> CHECK when the counter reaches 0.
- CHECK:
  - If FCLK_DATA==FRAME_PATTERN: match_cnt increments. When it reaches LOCK_COUNT -> LOCK.
  - On mismatch: match_cnt clears. If SLIP_COUNT==MAX_SLIPS -> FAIL, else -> SLIP.
- SLIP: BITSLIP=1 for exactly this one cycle; SLIP_COUNT increments; -> SETTLE.
- LOCK:
  - LOCKED=1.
  - A mismatch increments miss_cnt; a match clears it.
  - When miss_cnt reaches LOSS_COUNT: LOCK_LOST is set and the next state depends on configuration (see Configuration).
- FAIL: ALIGN_FAIL=1; the FSM stays in FAIL until ALIGN_START.
- ALIGN_START=1 in any state, including mid-settle or mid-lock, has highest priority:
  - Clears SLIP_COUNT, match_cnt, miss_cnt, LOCK_LOST and ALIGN_FAIL.
  - Next state is SETTLE.
  - Held high, it keeps the FSM re-entering SETTLE; alignment proceeds after it deasserts.
- A match and a mismatch cannot occur in the same cycle. Counters never wrap: SLIP_COUNT saturates at 31, and the other counters are compared with equality before incrementing.

## Timing
- All outputs are registered. Reset values: BITSLIP=0, LOCKED=0, ALIGN_FAIL=0, LOCK_LOST=0, SLIP_COUNT=0, STATE=IDLE.
- First cycle after RESETN deasserts: IDLE -> SETTLE.
- Slip loop cost: 1 (SLIP) + SETTLE_CYCLES + 1 (CHECK) cycles per slip.
- Already-aligned input: LOCKED rises 1 + SETTLE_CYCLES + LOCK_COUNT cycles after leaving IDLE, which is 13 cycles at defaults.
- LOCKED falls on the cycle that the LOSS_COUNT-th consecutive mismatch is registered.
- LOCKED also falls the cycle after ALIGN_START is sampled.
- BITSLIP pulses are never closer than SETTLE_CYCLES+2 cycles apart.
- Reset asserted mid-operation returns all outputs to their reset values immediately (asynchronous). Any BITSLIP pulse in flight is truncated.

## Configuration
- FRAME_ALIGN_AUTO_RELOCK_EN defined: on loss of lock, LOCK -> SETTLE with SLIP_COUNT and match_cnt cleared. LOCK_LOST stays set.
- FRAME_ALIGN_AUTO_RELOCK_EN undefined: on loss of lock, LOCK -> IDLE. init_pend stays 0, so the controller waits for ALIGN_START.

## Structure
- Shared package holds:
  - the state enumeration (3-bit codes above);
  - the counter width constants (5-bit slip counter, 4-bit settle/match/miss counters);
  - the default FRAME_PATTERN.
- One sub-module, frame_align_cnt: a generic load/enable/clear counter with a terminal-count compare. It is instantiated for the settle, match and miss counters.
- The FSM and the SLIP_COUNT saturation logic live in the top level.

## Test plan
- Reset, then FCLK_DATA held at 8'hF0 -> no BITSLIP; LOCKED=1 at cycle 13 after reset release; SLIP_COUNT=0.
- Bench model rotates the frame word one bit per BITSLIP, starting 3 slips from 8'hF0 -> exactly 3 BITSLIP pulses, each one cycle wide and spaced 6 cycles apart; then LOCKED=1 with SLIP_COUNT=3.
- FCLK_DATA held at 8'hAA -> 16 BITSLIP pulses, then ALIGN_FAIL=1, STATE=5, LOCKED=0; FSM stays in FAIL until ALIGN_START.
- While locked, inject 3 bad words, 1 good word, then 4 bad words -> the 3 bad words do not drop lock. After the 4th of the final bad words, LOCKED=0 and LOCK_LOST=1. With the macro: STATE goes to SETTLE and the FSM relocks. Without it: STATE=IDLE.
- ALIGN_START pulsed during SETTLE of slip #2 -> SLIP_COUNT clears to 0 and SETTLE restarts with a full SETTLE_CYCLES count.
- RESETN asserted during the SLIP cycle -> BITSLIP drops asynchronously; all outputs return to reset values; the automatic alignment restarts after release.
